// File: rtl/dtcm_ahb_slave.sv
// AHB-Lite slave front-end for the data TCM: word array with byte-lane writes, optional wait states.
// Optional feature: define DTCM_ERR_RESP_EN for a two-cycle ERROR response on illegal accesses.
module dtcm_ahb_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  // state | meaning
  // IDLE  | no data phase | WAIT | wait states | DATA | data phase, ready
  // ERR1  | error, stalled | ERR2 | error, completing
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
`ifdef DTCM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] a_idx;
  logic [3:0]    a_be;
  logic          a_write, a_legal;
  logic [31:0]   hrdata_q;

  logic          acc, acc_legal, in_range, misaligned, fwd_hit;
  logic [31:0]   off, wmerge, rd_word;
  logic [AW-1:0] acc_idx;
  logic [3:0]    acc_be;
  logic          unused_htrans;

  assign unused_htrans = htrans[0];

  assign hreadyout = (state_q != WAIT) && (state_q != ERR1);
  assign hresp     = (state_q == ERR1) || (state_q == ERR2);
  assign hrdata    = hrdata_q;

  assign acc        = hsel && htrans[1] && hready && hreadyout;
  assign off        = haddr - BASE_ADDR;
  assign acc_idx    = AW'(off >> 2);
  assign in_range   = (haddr >= BASE_ADDR) && ({1'b0, haddr} < LIMIT);
  assign misaligned = ((hsize == 3'd1) && haddr[0]) ||
                      ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign acc_legal  = in_range && (hsize <= 3'd2) && !misaligned;

  always_comb begin
    acc_be = 4'b0000;
    case (hsize)
      3'd0:    acc_be = 4'b0001 << haddr[1:0];
      3'd1:    acc_be = haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    acc_be = 4'b1111;
      default: acc_be = 4'b0000;
    endcase
  end

  // Write data merged onto the stored word; also the forwarding source for a
  // read whose address phase overlaps this write's data phase.
  always_comb begin
    wmerge = mem[a_idx];
    for (int b = 0; b < 4; b++)
      if (a_be[b]) wmerge[8*b +: 8] = hwdata[8*b +: 8];
  end

  assign fwd_hit = (state_q == DATA) && a_write && a_legal && (acc_idx == a_idx);
  assign rd_word = fwd_hit ? wmerge : mem[acc_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DATA, ERR2: begin
        state_d = IDLE;
        if (acc) begin
          if (ERR_EN && !acc_legal) begin
            state_d = ERR1;
          end else if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_CYCLES);
          end else begin
            state_d = DATA;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = DATA;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      a_idx   <= '0;
      a_be    <= 4'b0000;
      a_write <= 1'b0;
      a_legal <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc) begin
        a_idx   <= acc_idx;
        a_be    <= acc_be;
        a_write <= hwrite;
        a_legal <= acc_legal;
      end
    end
  end

  // Zero-wait reads fetch during the address phase; waited reads fetch on the last wait cycle.
  always_ff @(posedge hclk) begin
    if (hrst)
      hrdata_q <= '0;
    else if (acc && !hwrite && (WAIT_CYCLES == 0) && (acc_legal || !ERR_EN))
      hrdata_q <= acc_legal ? rd_word : '0;
    else if ((state_q == WAIT) && (cnt_q == 3'd1) && !a_write)
      hrdata_q <= a_legal ? mem[a_idx] : '0;
  end

  always_ff @(posedge hclk) begin
    if (!hrst && (state_q == DATA) && a_write && a_legal)
      mem[a_idx] <= wmerge;
  end

endmodule

// File: tb/tb_dtcm_ahb_slave.sv
// Directed self-checking bench: three slaves (0, 2 and 3 wait states) on a shared address/data bus.
module tb_dtcm_ahb_slave;

  logic        hclk = 1'b0;
  logic        hrst;
  logic        s0, s2, s3, rdy0;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        ro0, ro2, ro3, resp0, resp2, resp3;
  logic [31:0] rd0, rd2, rd3;
  int          vecs = 0;
  int          errs = 0;

  always #5 hclk = ~hclk;

  dtcm_ahb_slave #(.WAIT_CYCLES(0)) u0 (
    .hclk(hclk), .hrst(hrst), .hsel(s0), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hready(rdy0),
    .hreadyout(ro0), .hresp(resp0), .hrdata(rd0));

  dtcm_ahb_slave #(.WAIT_CYCLES(2)) u2 (
    .hclk(hclk), .hrst(hrst), .hsel(s2), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hready(ro2),
    .hreadyout(ro2), .hresp(resp2), .hrdata(rd2));

  dtcm_ahb_slave #(.WAIT_CYCLES(3)) u3 (
    .hclk(hclk), .hrst(hrst), .hsel(s3), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hready(ro3),
    .hreadyout(ro3), .hresp(resp3), .hrdata(rd3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle();
    s0 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    htrans = 2'b00;
  endtask

  // sel bit 0 -> u0, bit 1 -> u2, bit 2 -> u3
  task automatic phase(input logic [2:0] sel, input logic [31:0] a, input logic w,
                       input logic [2:0] sz);
    s0 = sel[0]; s2 = sel[1]; s3 = sel[2];
    haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
  endtask

  task automatic write0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    phase(3'b001, a, 1'b1, sz);
    cyc();
    chk("wr_ready", 32'(ro0), 32'd1);
    hwdata = d;
    idle();
    cyc();
  endtask

  task automatic read0(input string tag, input logic [31:0] a, input logic [31:0] exp);
    phase(3'b001, a, 1'b0, 3'd2);
    cyc();
    chk({tag, "_rdy"}, 32'(ro0), 32'd1);
    chk(tag, rd0, exp);
    idle();
  endtask

  task automatic illegal0(input string tag, input logic [31:0] a, input logic w,
                          input logic [2:0] sz, input logic [31:0] d, input logic [31:0] held);
    phase(3'b001, a, w, sz);
    cyc();
`ifdef DTCM_ERR_RESP_EN
    chk({tag, "_err1_resp"}, 32'(resp0), 32'd1);
    chk({tag, "_err1_rdy"}, 32'(ro0), 32'd0);
    idle();
    hwdata = d;
    cyc();
    chk({tag, "_err2_resp"}, 32'(resp0), 32'd1);
    chk({tag, "_err2_rdy"}, 32'(ro0), 32'd1);
    cyc();
    chk({tag, "_idle_resp"}, 32'(resp0), 32'd0);
    chk({tag, "_held"}, rd0, held);
`else
    chk({tag, "_resp"}, 32'(resp0), 32'd0);
    chk({tag, "_rdy"}, 32'(ro0), 32'd1);
    chk({tag, "_data"}, rd0, w ? held : 32'h0);
    hwdata = d;
    idle();
    cyc();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hrst = 1'b1; rdy0 = 1'b1;
    haddr = 32'h0; hwdata = 32'h0; hwrite = 1'b0; hsize = 3'd0;
    idle();
    repeat (3) cyc();
    chk("rst_rdy0", 32'(ro0), 32'd1);
    chk("rst_resp0", 32'(resp0), 32'd0);
    chk("rst_data0", rd0, 32'h0);
    chk("rst_rdy3", 32'(ro3), 32'd1);
    chk("rst_data2", rd2, 32'h0);
    hrst = 1'b0;
    cyc();

    // word write then read, zero wait states
    write0(32'h0001_0010, 3'd2, 32'hDEADBEEF);
    read0("word_rd", 32'h0001_0010, 32'hDEADBEEF);
    cyc();

    // byte/half lanes
    write0(32'h0001_0010, 3'd2, 32'h0000_0000);
    write0(32'h0001_0013, 3'd0, 32'hA5A5_A5A5);
    read0("byte_lane3", 32'h0001_0010, 32'hA500_0000);
    write0(32'h0001_0012, 3'd1, 32'h1234_BEEF);
    read0("half_upper", 32'h0001_0010, 32'h1234_0000);
    write0(32'h0001_0010, 3'd1, 32'hFFFF_5678);
    read0("half_lower", 32'h0001_0010, 32'h1234_5678);
    write0(32'h0001_0011, 3'd0, 32'h0000_C300);
    read0("byte_lane1", 32'h0001_0010, 32'h1234_C378);
    cyc();

    // write immediately followed by read of same word
    phase(3'b001, 32'h0001_0020, 1'b1, 3'd2);
    cyc();
    hwdata = 32'h1234_5678;
    phase(3'b001, 32'h0001_0020, 1'b0, 3'd2);
    cyc();
    chk("fwd_word_rdy", 32'(ro0), 32'd1);
    chk("fwd_word", rd0, 32'h1234_5678);
    phase(3'b001, 32'h0001_0021, 1'b1, 3'd0);
    cyc();
    hwdata = 32'h0000_AB00;
    phase(3'b001, 32'h0001_0020, 1'b0, 3'd2);
    cyc();
    chk("fwd_byte", rd0, 32'h1234_AB78);
    idle();
    cyc();

    // back-to-back reads
    read0("b2b_a", 32'h0001_0010, 32'h1234_C378);
    read0("b2b_b", 32'h0001_0020, 32'h1234_AB78);

    // phases that must be ignored
    s0 = 1'b1; haddr = 32'h0001_0020; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b01;
    cyc();
    chk("ign_hold", rd0, 32'h1234_AB78);
    chk("ign_rdy", 32'(ro0), 32'd1);
    hwdata = 32'hFFFF_FFFF;
    htrans = 2'b10; rdy0 = 1'b0;
    cyc();
    rdy0 = 1'b1; s0 = 1'b0;
    cyc();
    idle();
    cyc();
    read0("ign_unchanged", 32'h0001_0020, 32'h1234_AB78);

    // range boundaries and illegal accesses
    write0(32'h0001_0FFC, 3'd2, 32'hCAFE_F00D);
    write0(32'h0001_0000, 3'd2, 32'h0BAD_C0DE);
    read0("last_word", 32'h0001_0FFC, 32'hCAFE_F00D);
    illegal0("below_base", 32'h0000_FFFC, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    illegal0("above_end", 32'h0001_1000, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    illegal0("misalign_word", 32'h0001_0022, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    illegal0("misalign_half", 32'h0001_0021, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    illegal0("bad_size", 32'h0001_0020, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    illegal0("oob_read", 32'h0002_0000, 1'b0, 3'd2, 32'h0, 32'hCAFE_F00D);
    read0("first_word_kept", 32'h0001_0000, 32'h0BAD_C0DE);
    read0("last_word_kept", 32'h0001_0FFC, 32'hCAFE_F00D);
    read0("w8_kept", 32'h0001_0020, 32'h1234_AB78);
    cyc();

    // three wait states
    phase(3'b100, 32'h0001_0040, 1'b1, 3'd2);
    cyc();
    idle();
    hwdata = 32'h55AA_33CC;
    repeat (4) cyc();
    phase(3'b100, 32'h0001_0040, 1'b0, 3'd2);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("w3_low", 32'(ro3), 32'd0);
      cyc();
    end
    chk("w3_high", 32'(ro3), 32'd1);
    chk("w3_data", rd3, 32'h55AA_33CC);
    cyc();

    // reset in the middle of a waited write
    phase(3'b010, 32'h0001_0050, 1'b1, 3'd2);
    cyc();
    idle();
    hwdata = 32'h1111_1111;
    repeat (3) cyc();
    phase(3'b010, 32'h0001_0050, 1'b0, 3'd2);
    repeat (3) begin
      cyc();
      idle();
    end
    chk("w2_first_read", rd2, 32'h1111_1111);
    phase(3'b010, 32'h0001_0050, 1'b1, 3'd2);
    cyc();
    chk("w2_wait", 32'(ro2), 32'd0);
    idle();
    hwdata = 32'h2222_2222;
    hrst = 1'b1;
    cyc();
    chk("w2_rst_rdy", 32'(ro2), 32'd1);
    chk("w2_rst_resp", 32'(resp2), 32'd0);
    chk("w2_rst_data", rd2, 32'h0);
    hrst = 1'b0;
    cyc();
    phase(3'b010, 32'h0001_0050, 1'b0, 3'd2);
    cyc();
    idle();
    cyc();
    chk("w2_rd_wait", 32'(ro2), 32'd0);
    cyc();
    chk("w2_rd_rdy", 32'(ro2), 32'd1);
    chk("w2_old_word", rd2, 32'h1111_1111);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dtcm_ahb_slave.md
DTCM_AHB_SLAVE -- requirements
Module: dtcm_ahb_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0001_0000: byte address of the first memory word.
REQ-002 Parameter DEPTH, default 1024: number of 32-bit words; power of two.
REQ-003 Parameter WAIT_CYCLES, default 0, range 0..7: wait states inserted per read or write.
REQ-004 Port hclk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port hrst, input, 1: reset; synchronous and active-high.
REQ-006 Port hsel, input, 1: slave select.
REQ-007 Port haddr, input, 32: byte address of the transfer.
REQ-008 Port hwrite, input, 1: 1 = write, 0 = read.
REQ-009 Port hsize, input, 3: transfer size; 0 = byte, 1 = half, 2 = word.
REQ-010 Port htrans, input, 2: AHB transfer type; only bit 1 (NONSEQ/SEQ) starts a transfer.
REQ-011 Port hwdata, input, 32: write data, valid in the data phase.
REQ-012 Port hready, input, 1: bus-level ready; qualifies address-phase sampling.
REQ-013 Port hreadyout, output, 1: this slave's ready; drives the core's dtcm_hready.
REQ-014 Port hresp, output, 1: 0 = OKAY, 1 = ERROR; drives the core's dtcm_hresp.
REQ-015 Port hrdata, output, 32: read data; drives the core's dtcm_hrdata.

Function
REQ-016 Address phase SHALL be accepted only on a cycle with hsel=1, htrans[1]=1 and hready=1; the block SHALL register haddr, hwrite and hsize on acceptance.
REQ-017 FSM SHALL have states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-018 Transitions:
- IDLE -> WAIT on a legal accept when WAIT_CYCLES > 0; the wait counter loads WAIT_CYCLES.
- IDLE -> DATA on a legal accept when WAIT_CYCLES = 0.
- WAIT -> DATA when the counter reaches 1; the counter decrements each cycle in WAIT.
- DATA -> DATA on a new legal accept; otherwise DATA -> IDLE.
REQ-019 hreadyout SHALL be 0 in WAIT and ERR1, and 1 in IDLE, DATA and ERR2.
REQ-020 With WAIT_CYCLES=0, back-to-back transfers SHALL complete one per cycle with no bubble.
REQ-021 Read data SHALL be the full addressed word on hrdata during the cycle where hreadyout=1 in DATA; hrdata SHALL hold its last value otherwise.
REQ-022 Writes SHALL commit at the clock edge ending DATA, using hwdata.
REQ-023 Write byte lanes are little-endian:
- hsize 0 enables lane haddr[1:0].
- hsize 1 enables lanes {haddr[1],0} and {haddr[1],1}.
- hsize 2 enables all four lanes.
REQ-024 A read whose address phase coincides with the DATA cycle of a write to the same word SHALL return the merged new data (write forwarding).
REQ-025 The word index SHALL be (haddr-BASE_ADDR)[log2(DEPTH)+1:2].
REQ-026 An access is illegal if any of the following holds:
- haddr < BASE_ADDR;
- haddr >= BASE_ADDR + 4*DEPTH;
- hsize > 2;
- it is misaligned (half with haddr[0]=1; word with haddr[1:0]!=0).
REQ-027 The block SHALL ignore address phases where hsel=0, htrans[1]=0 or hready=0.

Reset
REQ-028 While hrst=1 the block SHALL hold state IDLE, wait counter 0, hreadyout=1, hresp=0 and hrdata=0.
REQ-029 Assertion of hrst mid-transfer SHALL abort the transfer; a pending write SHALL NOT commit.
REQ-030 Memory contents SHALL NOT be reset.

Configuration
REQ-031 Macro DTCM_ERR_RESP_EN, when defined, SHALL make an illegal access produce the AHB two-cycle error response:
- ERR1: hresp=1, hreadyout=0.
- ERR2: hresp=1, hreadyout=1.
- Memory is unchanged.
- Then IDLE, or DATA/WAIT if a new transfer is accepted in ERR2.
REQ-032 Without DTCM_ERR_RESP_EN, an illegal access SHALL complete with OKAY on the normal legal timing: reads return 32'h0 and writes are discarded.

Verification
REQ-033 Word write 32'hDEADBEEF to 0x0001_0010, then read 0x0001_0010 with WAIT_CYCLES=0 -> hrdata=32'hDEADBEEF in the read's data cycle, hreadyout never 0.
REQ-034 Byte write 8'hA5 (hwdata=32'hA5A5A5A5) to 0x0001_0013 over word 32'h00000000, then word read -> 32'hA5000000.
REQ-035 WAIT_CYCLES=3, single read -> hreadyout low for exactly 3 cycles, data valid on the 4th cycle after the address phase.
REQ-036 Back-to-back word write 32'h12345678 to 0x0001_0020 then read of 0x0001_0020 on the next cycle -> hrdata=32'h12345678 (forwarding).
REQ-037 Read of 0x0002_0000 with DTCM_ERR_RESP_EN -> hresp=1/hreadyout=0, then hresp=1/hreadyout=1, then IDLE; without the macro -> single OKAY cycle, hrdata=0.
REQ-038 hrst=1 asserted during WAIT of a write with WAIT_CYCLES=2 -> next cycle hreadyout=1, hresp=0, hrdata=0; a later read shows the old word.
